// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with x0 hardwired to zero and a
// post-reset clear sweep. Optional same-cycle write forwarding: RF_BYPASS_EN.
module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NR_RD*DATA_WIDTH-1:0] rdata,
    output logic                        ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [ADDR_WIDTH-1:0]   r_clrIdx;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_rf [DEPTH];
    logic                    w_sweepLast;
    logic                    w_clearing;
    logic                    w_storeEn;

    assign w_sweepLast = (r_clrIdx == ADDR_WIDTH'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == CLEAR && w_sweepLast) begin
            w_nextState = RUN;
        end
    end

    always_comb begin
        w_clearing = (r_state == CLEAR);
        w_storeEn  = (r_state == RUN) && wen && (waddr != '0);
    end

    // The sweep starts at 1 because x0 is never stored; ready flips on the
    // same edge that clears the top register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clrIdx <= ADDR_WIDTH'(1);
            r_ready  <= 1'b0;
        end else if (w_clearing) begin
            if (w_sweepLast) begin
                r_ready <= 1'b1;
            end else begin
                r_clrIdx <= r_clrIdx + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clearing) begin
                r_rf[r_clrIdx] <= '0;
            end else if (w_storeEn) begin
                r_rf[waddr] <= wdata;
            end
        end
    end

    assign ready = r_ready;

    for (genvar g = 0; g < NR_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_rd;

        assign w_ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rd = '0;
            if (!w_clearing && w_ra != '0) begin
                w_rd = r_rf[w_ra];
`ifdef RF_BYPASS_EN
                if (w_storeEn && w_ra == waddr) begin
                    w_rd = wdata;
                end
`else
`endif
            end
        end

        assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the NPC core. Successor to the single-read-port register file.
- Adds N read ports and one write port, with x0 hardwired to zero.
- Adds a hardware clear sequencer: after reset it zeroes every register, one per cycle, before asserting ready.
- Sits between decode (read ports) and writeback (write port). The pipeline controller holds instruction issue until ready is high.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 32, register data width.
NR_RD, 2, number of independent read ports (>=1).

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
wen  input  1  write enable
waddr  input  ADDR_WIDTH  write index
wdata  input  DATA_WIDTH  write data
raddr  input  NR_RD*ADDR_WIDTH  packed read indices; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  NR_RD*DATA_WIDTH  packed read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
ready  output  1  high once the clear sweep is done and the file accepts writes

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low. It is sampled only on the rising edge of clk.
- FSM states: CLEAR, RUN.
- On any edge with rst_n=0:
  - state <= CLEAR, clr_idx <= 1, ready <= 0.
  - Register contents are not directly reset; the sweep clears them.
- CLEAR state, each edge with rst_n=1:
  - rf[clr_idx] <= 0.
  - If clr_idx == 2**ADDR_WIDTH-1: state <= RUN, ready <= 1.
  - Otherwise: clr_idx <= clr_idx+1.
- Sweep length: with defaults, 31 clearing edges after rst_n rises. ready is high from the edge that clears register 31 onward.
- Writes in CLEAR are dropped silently. wen is ignored and no register other than clr_idx changes.
- Reads in CLEAR: every rdata port returns 0.
- RUN state write: on an edge with wen=1 and waddr!=0, rf[waddr] <= wdata. Writes with waddr==0 are discarded.
- RUN state read: combinational. rdata port i = 0 if raddr_i==0, else rf[raddr_i].
- Without bypass, a read of a register written on the same edge returns the old value until after that edge.
- Multiple ports may read the same index in the same cycle; all return identical data.
- Reset mid-sweep or mid-run:
  - ready drops on the reset edge.
  - The sweep restarts from index 1.
  - Partially written data is overwritten by the sweep.
- x0 is never stored to. Its read value is constant 0 in every state.
- No read or write latency beyond the above; no backpressure on the write port.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: in RUN, if wen=1, waddr!=0 and raddr_i==waddr, port i returns wdata combinationally in the same cycle (write-before-read forwarding). The forwarding is applied independently per port.
- Not defined: no forwarding. Reads always return the stored array value.
- Bypass is never active in CLEAR or for index 0.

Test Plan:
- Reset sweep: hold rst_n=0 for 2 cycles, then release.
  - ready must stay 0 for 30 edges and rise on the 31st.
  - Afterwards, reading all 32 indices on both ports returns 0x00000000.
- Write/read: in RUN, write 0xDEADBEEF to x5, then 0x12345678 to x31.
  - Next cycle, raddr0=5 returns 0xDEADBEEF and raddr1=31 returns 0x12345678.
  - raddr0=raddr1=5 returns 0xDEADBEEF on both ports.
- x0 protection: write 0xFFFFFFFF to x0 with wen=1 -> reading x0 on any port returns 0.
- Write during CLEAR: release reset, then on cycle 3 drive wen=1, waddr=20, wdata=0xAAAA5555.
  - After ready, x20 reads 0.
  - All rdata read 0 during the sweep.
- Reset mid-run: load x7=0x0000CAFE, then pulse rst_n=0 for 1 cycle.
  - ready drops to 0 on the reset edge.
  - After the 31-edge sweep completes, x7 reads 0.
- Same-cycle collision: wen=1, waddr=9, wdata=0x55, raddr0=9, with x9 previously 0x11.
  - With RF_BYPASS_EN: rdata0=0x55 in that cycle.
  - Without it: rdata0=0x11 in that cycle and 0x55 on the next cycle.
